// File: rtl/poly_pkg.sv
// Shared types and elaboration helpers for the poly_reduce fold stage.
package poly_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    MUL,
    FIN,
    DONE
  } state_t;

  // Width of the MSB-first bit counter over zeta; never below one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Q must sit strictly between 2^(N-1) and 2^N so one conditional subtract
  // fully reduces any N-bit value and any sum of two residues.
  function automatic bit modulus_ok(input int n, input int q);
    return (n >= 2) && (n <= 30) && (q > (1 << (n - 1))) && (q < (1 << n));
  endfunction

endpackage

// File: rtl/mod_add.sv
// Combinational a + b mod Q using one N+1-bit add and a single conditional subtract.
module mod_add #(
  parameter int N = 2,
  parameter int Q = 3
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum
);

  localparam logic [N:0] QW = (N+1)'(Q);

  logic [N:0] raw;

  assign raw = {1'b0, a} + {1'b0, b};
  assign sum = (raw >= QW) ? N'(raw - QW) : N'(raw);

endmodule

// File: rtl/poly_reduce.sv
// Folds {p2,p1,p0} modulo (X^2 - zeta) and Q via an N-cycle serial modular multiply.
// Define POLY_REDUCE_SUB_EN to fold modulo (X^2 + zeta) instead.
module poly_reduce
  import poly_pkg::*;
#(
  parameter int N = 2,
  parameter int Q = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [3*N-1:0] in_p,
  input  logic [N-1:0]   zeta,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] out_c
);

  localparam int          CNT_W = cnt_width(N);
  localparam logic [N-1:0] QN   = N'(Q);

  generate
    if (!modulus_ok(N, Q)) begin : g_bad_modulus
      $error("poly_reduce: Q must satisfy 2^(N-1) < Q < 2^N");
    end
  endgenerate

  state_t           state, state_nxt;
  logic [N-1:0]     p0, p1, p2, zeta_r, acc;
  logic [CNT_W-1:0] cnt;
  logic [N-1:0]     acc_dbl, acc_add, fold_b, fold;

  function automatic logic [N-1:0] pre_red(input logic [N-1:0] x);
    return (x >= QN) ? x - QN : x;
  endfunction

  mod_add #(.N(N), .Q(Q)) u_dbl  (.a(acc),     .b(acc),    .sum(acc_dbl));
  mod_add #(.N(N), .Q(Q)) u_add  (.a(acc_dbl), .b(p2),     .sum(acc_add));
  mod_add #(.N(N), .Q(Q)) u_fold (.a(p0),      .b(fold_b), .sum(fold));

`ifdef POLY_REDUCE_SUB_EN
  // Q - acc lies in [1, Q]; p0 + (Q - acc) < 2Q, so one subtract still suffices.
  assign fold_b = QN - acc;
`else
  assign fold_b = acc;
`endif

  // NOTE: next-state logic assigns its default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = PRE;
      PRE:     state_nxt = MUL;
      MUL:     if (cnt == '0) state_nxt = FIN;
      FIN:     state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      p0     <= '0;
      p1     <= '0;
      p2     <= '0;
      zeta_r <= '0;
      acc    <= '0;
      cnt    <= '0;
      out_c  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (in_valid) begin
          p2     <= in_p[3*N-1:2*N];
          p1     <= in_p[2*N-1:N];
          p0     <= in_p[N-1:0];
          zeta_r <= zeta;
        end
        PRE: begin
          p0  <= pre_red(p0);
          p1  <= pre_red(p1);
          p2  <= pre_red(p2);
          acc <= '0;
          cnt <= CNT_W'(N - 1);
        end
        MUL: begin
          acc <= zeta_r[cnt] ? acc_add : acc_dbl;
          cnt <= cnt - CNT_W'(1);
        end
        FIN:     out_c <= {p1, fold};
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

endmodule

// File: tb/tb_poly_reduce.sv
// Scoreboard bench for poly_reduce: an N=2,Q=3 and an N=4,Q=13 instance, directed plus random streaming.
module tb_poly_reduce;

`ifdef POLY_REDUCE_SUB_EN
  localparam bit SUB = 1'b1;
`else
  localparam bit SUB = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance a: N=2, Q=3
  logic       rst_a = 1'b1, iv_a = 1'b0, ir_a, ov_a, or_a = 1'b0;
  logic [5:0] p_a = '0;
  logic [1:0] z_a = '0;
  logic [3:0] c_a;
  // Instance b: N=4, Q=13
  logic        rst_b = 1'b1, iv_b = 1'b0, ir_b, ov_b, or_b = 1'b0;
  logic [11:0] p_b = '0;
  logic [3:0]  z_b = '0;
  logic [7:0]  c_b;

  poly_reduce #(.N(2), .Q(3)) u_a (
    .clk(clk), .rst(rst_a), .in_valid(iv_a), .in_ready(ir_a), .in_p(p_a), .zeta(z_a),
    .out_valid(ov_a), .out_ready(or_a), .out_c(c_a)
  );

  poly_reduce #(.N(4), .Q(13)) u_b (
    .clk(clk), .rst(rst_b), .in_valid(iv_b), .in_ready(ir_b), .in_p(p_b), .zeta(z_b),
    .out_valid(ov_b), .out_ready(or_b), .out_c(c_b)
  );

  typedef struct {
    logic [7:0] c;
    int         acc_edge;
  } exp_t;

  exp_t q_a[$], q_b[$];
  int   n_checks = 0, n_errors = 0;
  bit   rand_rdy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the polynomial fold.
  function automatic logic [7:0] model(input int n, input int q, input logic [11:0] p, input logic [3:0] z);
    int mask, p0, p1, p2, prod, c0;
    mask = (1 << n) - 1;
    p0   = int'(p) & mask;
    p1   = (int'(p) >> n) & mask;
    p2   = (int'(p) >> (2 * n)) & mask;
    prod = (p2 * int'(z)) % q;
    c0   = SUB ? ((p0 % q) - prod + q) % q : ((p0 % q) + prod) % q;
    return 8'((((p1 % q) << n) | c0));
  endfunction

  // Drivers: called at posedge+1, return at posedge+1 after the accept edge.
  task automatic send_a(input logic [5:0] p, input logic [1:0] z, input logic [3:0] exp);
    bit got = 1'b0;
    iv_a = 1'b1; p_a = p; z_a = z;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ir_a) begin got = 1'b1; break; end
    end
    if (got) q_a.push_back('{c: {4'h0, exp}, acc_edge: cyc + 1});
    else check("a_accept_timeout", 0, 1);
    @(posedge clk); #1;
    iv_a = 1'b0;
  endtask

  task automatic send_b(input logic [11:0] p, input logic [3:0] z, input logic [7:0] exp);
    bit got = 1'b0;
    iv_b = 1'b1; p_b = p; z_b = z;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ir_b) begin got = 1'b1; break; end
    end
    if (got) q_b.push_back('{c: exp, acc_edge: cyc + 1});
    else check("b_accept_timeout", 0, 1);
    @(posedge clk); #1;
    iv_b = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (q_a.size() == 0 && q_b.size() == 0) break;
    end
    check("drain_pending", q_a.size() + q_b.size(), 0);
    @(posedge clk); #1;
  endtask

  // Monitors: latency on first valid of a job, payload at each handshake.
  initial begin : mon_a
    bit   seen = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_a) seen = 1'b0;
      else if (ov_a) begin
        if (q_a.size() == 0) begin
          check("a_unexpected_output", 1, 0);
        end else begin
          if (!seen) begin
            check("a_latency", cyc + 1 - q_a[0].acc_edge, 5);
            seen = 1'b1;
          end
          if (or_a) begin
            e = q_a.pop_front();
            check("a_out_c", {4'h0, c_a}, e.c);
            seen = 1'b0;
          end
        end
      end
    end
  end

  initial begin : mon_b
    bit   seen = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_b) seen = 1'b0;
      else if (ov_b) begin
        if (q_b.size() == 0) begin
          check("b_unexpected_output", 1, 0);
        end else begin
          if (!seen) begin
            check("b_latency", cyc + 1 - q_b[0].acc_edge, 7);
            seen = 1'b1;
          end
          if (or_b) begin
            e = q_b.pop_front();
            check("b_out_c", c_b, e.c);
            seen = 1'b0;
          end
        end
      end
    end
  end

  initial begin : ready_gen
    forever begin
      @(posedge clk); #1;
      if (rand_rdy) begin
        or_a = 1'($urandom_range(0, 1));
        or_b = 1'($urandom_range(0, 3) != 0);
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [11:0] pb;
    logic [3:0]  zb;
    logic [7:0]  eb;
    logic [5:0]  pa;
    logic [1:0]  za;

    repeat (3) @(posedge clk);
    #1;
    rst_a = 1'b0;
    rst_b = 1'b0;
    @(negedge clk);
    check("a_rst_in_ready", ir_a, 1);
    check("a_rst_out_valid", ov_a, 0);
    check("a_rst_out_c", c_a, 0);
    check("b_rst_in_ready", ir_b, 1);
    check("b_rst_out_valid", ov_b, 0);
    check("b_rst_out_c", c_b, 0);
    @(posedge clk); #1;

    // Directed vectors
    or_a = 1'b1;
    or_b = 1'b1;
    send_a({2'd2, 2'd3, 2'd1}, 2'd2, SUB ? 4'b0000 : 4'b0010);
    send_b({4'd15, 4'd14, 4'd12}, 4'd7, SUB ? 8'h1B : 8'h10);
    drain();
    send_b({4'd9, 4'd5, 4'd14}, 4'd0, 8'h51);
    send_b({4'd12, 4'd0, 4'd0}, 4'd15, SUB ? 8'h02 : 8'h0B);
    drain();

    // Reset in the middle of a job on instance a
    send_a({2'd3, 2'd2, 2'd2}, 2'd3, 4'h0);
    @(posedge clk); #1;
    rst_a = 1'b1;
    q_a.delete();
    @(posedge clk); #1;
    rst_a = 1'b0;
    @(negedge clk);
    check("a_midrst_in_ready", ir_a, 1);
    check("a_midrst_out_valid", ov_a, 0);
    check("a_midrst_out_c", c_a, 0);
    @(posedge clk); #1;
    pa = 6'b01_10_11;
    send_a(pa, 2'd1, model(2, 3, {6'h0, pa}, 4'd1));
    drain();

    // Back-pressure on instance b
    or_b = 1'b0;
    pb = 12'($urandom);
    zb = 4'($urandom);
    eb = model(4, 13, pb, zb);
    send_b(pb, zb, eb);
    begin
      bit up = 1'b0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (ov_b) begin up = 1'b1; break; end
      end
      check("bp_valid_timeout", up, 1);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      iv_b = 1'($urandom_range(0, 1));
      p_b  = 12'($urandom);
      @(negedge clk);
      check("bp_out_valid", ov_b, 1);
      check("bp_out_c", c_b, eb);
      check("bp_in_ready", ir_b, 0);
    end
    @(posedge clk); #1;
    iv_b = 1'b0;
    or_b = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_release_in_ready", ir_b, 1);
    check("bp_release_out_valid", ov_b, 0);
    check("bp_queue_empty", q_b.size(), 0);
    repeat (10) @(posedge clk);
    #1;

    // Randomized streaming with random back-pressure
    rand_rdy = 1'b1;
    fork
      for (int i = 0; i < 3000; i++) begin
        pa = 6'($urandom);
        za = 2'($urandom);
        send_a(pa, za, 4'(model(2, 3, {6'h0, pa}, {2'h0, za})));
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      for (int i = 0; i < 3000; i++) begin
        pb = 12'($urandom);
        zb = 4'($urandom);
        send_b(pb, zb, model(4, 13, pb, zb));
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
    join
    rand_rdy = 1'b0;
    @(posedge clk); #1;
    or_a = 1'b1;
    or_b = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
